// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. It computes z = x - y (mod 2^WIDTH), one bit
// per clock and LSB first, using a single full-subtractor cell and a registered
// borrow. A start/done handshake wraps the datapath, so a controller can spend
// WIDTH+2 cycles per difference instead of a full-width subtractor.
//
// Parameters:
//   WIDTH   operand/result width in bits (1..32)
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while idle
//   x       minuend, captured on the edge that accepts start
//   y       subtrahend, captured on the same edge
//   busy    high while an operation is running or completing
//   done    one-cycle pulse; z and borrow are valid from this cycle
//   z       difference (x - y) mod 2^WIDTH, held until the next completion
//   borrow  1 when x < y (unsigned), held like z
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow
);

  // The counter needs at least one bit even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] diff_next;

  // Full-subtractor cell on the current LSBs. The new difference bit enters
  // at the MSB so that after WIDTH shifts the result is in natural order.
  always_comb begin
    d         = a[0] ^ b[0] ^ br;
    br_next   = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    diff_next = diff >> 1;
    diff_next[WIDTH-1] = d;
  end

  // Control FSM and datapath. z/borrow are loaded from the next-state values
  // on the final RUN edge, so they are valid in the same cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      diff   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a     <= x;
            b     <= y;
            diff  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a    <= a >> 1;
          b    <= b >> 1;
          br   <= br_next;
          diff <= diff_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            z      <= diff_next;
            borrow <= br_next;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
